dm_capture_writer: RTL and testbench
====================================

DM_CAPTURE_WRITER -- requirements
Module: dm_capture_writer

Interface
REQ-001 Parameter: STEP, 1, unsigned magnitude added to or subtracted from the accumulator per received bit (1..127).
REQ-002 Parameter: INIT, 0, signed 8-bit accumulator value loaded on reset and on capture start.
REQ-003 Port: CLK100MHZ  input  1  clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high.
REQ-005 Port: start  input  1  level or pulse; begins a capture when sampled high in IDLE or DONE.
REQ-006 Port: bit_valid  input  1  qualifies enc_bit for one cycle.
REQ-007 Port: enc_bit  input  1  delta-modulation bit: 1 = up, 0 = down.
REQ-008 Port: rd_addr  input  4  buffer read address.
REQ-009 Port: rd_data  output  8  signed buffer contents at rd_addr, registered.
REQ-010 Port: sample  output  8  signed most recently reconstructed sample.
REQ-011 Port: busy  output  1  high in CAPTURE.
REQ-012 Port: done  output  1  high in DONE.
REQ-013 Port: count  output  5  samples written since the last start (0..16).

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURE and DONE, with IDLE entered on reset.
REQ-015 IDLE/DONE with start=1 SHALL go to CAPTURE next cycle and load accumulator=INIT, wr_addr=0, count=0.
REQ-016 start while in CAPTURE SHALL be ignored.
REQ-017 In CAPTURE, each bit_valid=1 SHALL set acc = sat(acc + STEP) for enc_bit=1 or sat(acc - STEP) for enc_bit=0.
REQ-018 Saturation SHALL clamp the result to [-128, 127], computed at 9-bit signed width.
REQ-019 The same edge SHALL write the new acc to mem[wr_addr], increment wr_addr modulo 16, increment count, and update sample.
REQ-020 The latency from bit_valid to the sample/mem update SHALL be one clock.
REQ-021 bit_valid outside CAPTURE SHALL be ignored, with no accumulator, memory or count change.
REQ-022 The 16th write SHALL move CAPTURE to DONE on the same edge, with count=16.
REQ-023 The buffer SHALL have 16 entries of 8 bits.
REQ-024 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is presented.
REQ-025 A read and write to the same address on the same edge SHALL return the old value (read-first).
REQ-026 Reads SHALL be permitted in every state.

Reset
REQ-027 reset SHALL take priority over all inputs, including start and bit_valid.
REQ-028 Reset values SHALL be: state=IDLE, acc=sample=INIT, wr_addr=0, count=0, busy=0, done=0, rd_data=0, and all 16 mem entries=0.
REQ-029 reset asserted mid-capture SHALL abort the capture, and no write SHALL occur on that edge.

Configuration
REQ-030 With DM_CAPTURE_WRAP_EN defined, the 16th write SHALL NOT enter DONE; wr_addr SHALL wrap to 0, capture SHALL continue, and count SHALL saturate at 16 (ring buffer, stopped only by reset).
REQ-031 Without DM_CAPTURE_WRAP_EN, the behaviour of REQ-022 SHALL apply.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, CAPTURE, DONE), DEPTH=16, ADDR_W=4, DATA_W=8, SMAX=127 and SMIN=-128.
REQ-033 A single sub-module, dm_sat_accum, SHALL implement the saturating accumulator: acc, enc_bit and enable in, acc out.
REQ-034 The buffer SHALL be inferred register or BRAM storage, with no vendor IP instance.

Verification
REQ-035 The bench SHALL cover: reset, start, then 16 valid 1-bits with STEP=1 -> mem[0..15]=1..16, count=16, done=1, busy=0.
REQ-036 The bench SHALL cover: INIT=120, STEP=4, ten 1-bits -> samples 124, 127, 127, ...; no overflow past 127.
REQ-037 The bench SHALL cover: INIT=-120, STEP=4, ten 0-bits -> samples -124, -128, -128, ...
REQ-038 The bench SHALL cover: reset asserted after 5 writes -> state IDLE, count=0, mem all 0, sample=INIT; a following start writes from address 0.
REQ-039 The bench SHALL cover: bit_valid pulses in IDLE and DONE, and start asserted mid-capture -> no change to mem, count or address.
REQ-040 The bench SHALL cover: with DM_CAPTURE_WRAP_EN defined, 20 1-bits -> mem[0..3]=17..20, mem[4..15]=5..16, busy=1, done=0, count=16.

Source files
------------

// File: rtl/dm_capture_writer_pkg.sv
//------------------------------------------------------------------------------
// dm_capture_writer_pkg : shared types, sizes and the saturation helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dm_capture_writer_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;
  localparam int SMAX   = 127;
  localparam int SMIN   = -128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Clamp a 9-bit signed intermediate back into the 8-bit signed range.
  function automatic logic signed [DATA_W-1:0] sat9(input logic signed [DATA_W:0] v);
    if (v > $signed((DATA_W+1)'(SMAX)))
      return DATA_W'(SMAX);
    else if (v < $signed((DATA_W+1)'(SMIN)))
      return DATA_W'(SMIN);
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_sat_accum.sv
//------------------------------------------------------------------------------
// dm_sat_accum : next value of the delta-modulation accumulator, saturating
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_sat_accum
  import dm_capture_writer_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic signed [DATA_W-1:0] acc_i,
  input  logic                     enc_bit_i,
  input  logic                     en_i,
  output logic signed [DATA_W-1:0] acc_o
);

  localparam logic signed [DATA_W:0] c_STEP9 = (DATA_W+1)'(STEP);

  logic signed [DATA_W:0] w_ext;
  logic signed [DATA_W:0] w_sum;

  always_comb begin
    w_ext = {acc_i[DATA_W-1], acc_i};
    w_sum = enc_bit_i ? (w_ext + c_STEP9) : (w_ext - c_STEP9);
    acc_o = en_i ? sat9(w_sum) : acc_i;
  end

endmodule

`default_nettype wire

// File: rtl/dm_capture_writer.sv
//------------------------------------------------------------------------------
// dm_capture_writer : captures 16 reconstructed delta-mod samples into a buffer
// Option: DM_CAPTURE_WRAP_EN turns the buffer into a free-running ring.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_capture_writer
  import dm_capture_writer_pkg::*;
#(
  parameter int unsigned              STEP = 1,
  parameter logic signed [DATA_W-1:0] INIT = '0
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bit_valid,
  input  logic                     enc_bit,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic signed [DATA_W-1:0] sample,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         count
);

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] rd_data_q;
  logic signed [DATA_W-1:0] mem_q [DEPTH];

  logic w_wr;
  logic w_start;

  dm_sat_accum #(
    .STEP (STEP)
  ) u_accum (
    .acc_i     (acc_q),
    .enc_bit_i (enc_bit),
    .en_i      (w_wr),
    .acc_o     (acc_d)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = CAPTURE;
      CAPTURE: begin
`ifndef DM_CAPTURE_WRAP_EN
        if (w_wr && (count_q == CNT_W'(DEPTH - 1))) state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == CAPTURE);
    done    = (state_q == DONE);
    w_wr    = (state_q == CAPTURE) && bit_valid;
    w_start = (state_q != CAPTURE) && start;
  end

  always_comb begin
    wr_addr_d = wr_addr_q + ADDR_W'(1);
`ifdef DM_CAPTURE_WRAP_EN
    // Ring mode keeps writing forever; the count only reports a full buffer.
    count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
`else
    count_d = count_q + CNT_W'(1);
`endif
  end

  // Read is taken from the pre-edge array contents, so a same-address write
  // on this edge is not visible until the following read.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      acc_q     <= INIT;
      wr_addr_q <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
      if (w_start) begin
        acc_q     <= INIT;
        wr_addr_q <= '0;
        count_q   <= '0;
      end else if (w_wr) begin
        acc_q            <= acc_d;
        mem_q[wr_addr_q] <= acc_d;
        wr_addr_q        <= wr_addr_d;
        count_q          <= count_d;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign sample  = acc_q;
  assign count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_capture_writer.sv
//------------------------------------------------------------------------------
// tb_dm_capture_writer : three parameterisations against a behavioural model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_capture_writer;

  localparam int N = 3;
`ifdef DM_CAPTURE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       CLK100MHZ = 1'b0;
  logic       reset;
  logic       start;
  logic       bit_valid;
  logic [3:0] rd_addr;
  logic       enc       [N];
  logic [7:0] rd_data_w [N];
  logic [7:0] sample_w  [N];
  logic       busy_w    [N];
  logic       done_w    [N];
  logic [4:0] count_w   [N];

  always #5 CLK100MHZ = ~CLK100MHZ;

  dm_capture_writer #(.STEP(1), .INIT(8'sd0)) u_dut0 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .bit_valid(bit_valid),
    .enc_bit(enc[0]), .rd_addr(rd_addr), .rd_data(rd_data_w[0]), .sample(sample_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .count(count_w[0]));

  dm_capture_writer #(.STEP(4), .INIT(8'sd120)) u_dut1 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .bit_valid(bit_valid),
    .enc_bit(enc[1]), .rd_addr(rd_addr), .rd_data(rd_data_w[1]), .sample(sample_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .count(count_w[1]));

  dm_capture_writer #(.STEP(4), .INIT(-8'sd120)) u_dut2 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .bit_valid(bit_valid),
    .enc_bit(enc[2]), .rd_addr(rd_addr), .rd_data(rd_data_w[2]), .sample(sample_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .count(count_w[2]));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s[dut%0d] t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int init_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 120 : -120);
  endfunction

  function automatic int clamp(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Behavioural model: 0 = idle, 1 = capturing, 2 = finished.
  int m_state [N];
  int m_acc   [N];
  int m_wr    [N];
  int m_cnt   [N];
  int m_rd    [N];
  int m_mem   [N][16];

  always @(posedge CLK100MHZ) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_state[k] = 0;
        m_acc[k]   = init_of(k);
        m_wr[k]    = 0;
        m_cnt[k]   = 0;
        m_rd[k]    = 0;
        for (int j = 0; j < 16; j++) m_mem[k][j] = 0;
      end else begin
        m_rd[k] = m_mem[k][rd_addr];
        if (m_state[k] != 1) begin
          if (start) begin
            m_state[k] = 1;
            m_acc[k]   = init_of(k);
            m_wr[k]    = 0;
            m_cnt[k]   = 0;
          end
        end else if (bit_valid) begin
          m_acc[k] = clamp(m_acc[k] + (enc[k] ? step_of(k) : -step_of(k)));
          m_mem[k][m_wr[k]] = m_acc[k];
          m_wr[k] = (m_wr[k] + 1) % 16;
          if (m_cnt[k] < 16) m_cnt[k]++;
          if (!WRAP && m_cnt[k] == 16) m_state[k] = 2;
        end
      end
    end
  end

  always @(negedge CLK100MHZ) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        chk("sample",  k, int'($signed(sample_w[k])),  m_acc[k]);
        chk("rd_data", k, int'($signed(rd_data_w[k])), m_rd[k]);
        chk("count",   k, int'(count_w[k]),            m_cnt[k]);
        chk("busy",    k, int'(busy_w[k]),             int'(m_state[k] == 1));
        chk("done",    k, int'(done_w[k]),             int'(m_state[k] == 2));
      end
    end
  end

  task automatic tick();
    @(negedge CLK100MHZ);
    #1;
  endtask

  task automatic set_enc(input logic b);
    enc[0] = b;
    enc[1] = b;
    enc[2] = ~b;
  endtask

  task automatic read_check(input int a, input int exp0);
    rd_addr = 4'(a);
    tick();
    chk("lit_mem", 0, int'($signed(rd_data_w[0])), exp0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0; rd_addr = '0;
    set_enc(1'b0);
    tick();
    tick();
    chk_en = 1'b1;
    chk("lit_rst_count",  0, int'(count_w[0]), 0);
    chk("lit_rst_sample", 1, int'($signed(sample_w[1])), 120);
    chk("lit_rst_sample", 2, int'($signed(sample_w[2])), -120);
    chk("lit_rst_busy",   0, int'(busy_w[0]), 0);

    // Sixteen up-bits (down-bits for dut2).
    reset = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1; set_enc(1'b1);
      tick();
      if (i == 0) begin
        chk("lit_sat_up", 1, int'($signed(sample_w[1])), 124);
        chk("lit_sat_dn", 2, int'($signed(sample_w[2])), -124);
      end else if (i == 1 || i == 9) begin
        chk("lit_sat_up", 1, int'($signed(sample_w[1])), 127);
        chk("lit_sat_dn", 2, int'($signed(sample_w[2])), -128);
      end
    end
    bit_valid = 1'b0;
    chk("lit_full_count", 0, int'(count_w[0]), 16);
    chk("lit_full_done",  0, int'(done_w[0]), WRAP ? 0 : 1);
    chk("lit_full_busy",  0, int'(busy_w[0]), WRAP ? 1 : 0);
    for (int a = 0; a < 16; a++) read_check(a, a + 1);

    // Four more bits: ignored once done, overwrite the oldest in ring mode.
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; set_enc(1'b1); tick();
    end
    bit_valid = 1'b0;
    chk("lit_post_count", 0, int'(count_w[0]), 16);
    chk("lit_post_busy",  0, int'(busy_w[0]), WRAP ? 1 : 0);
    for (int a = 0; a < 16; a++) read_check(a, (WRAP && a < 4) ? 17 + a : a + 1);

    // bit_valid in IDLE, start mid-capture, then reset mid-capture.
    reset = 1'b1; tick(); reset = 1'b0;
    bit_valid = 1'b1; tick(); tick(); bit_valid = 1'b0;
    chk("lit_idle_count", 0, int'(count_w[0]), 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; set_enc(1'b1); tick();
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_midstart_count", 0, int'(count_w[0]), 4);
    chk("lit_midstart_sample", 0, int'($signed(sample_w[0])), 4);
    tick();
    reset = 1'b1; tick(); reset = 1'b0; bit_valid = 1'b0;
    chk("lit_abort_count",  0, int'(count_w[0]), 0);
    chk("lit_abort_sample", 1, int'($signed(sample_w[1])), 120);
    chk("lit_abort_busy",   0, int'(busy_w[0]), 0);
    for (int a = 0; a < 16; a++) read_check(a, 0);
    start = 1'b1; tick(); start = 1'b0;
    bit_valid = 1'b1; set_enc(1'b1); tick(); bit_valid = 1'b0;
    read_check(0, 1);
    read_check(1, 0);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(63) == 0);
      start     = ($urandom_range(11) == 0);
      bit_valid = $urandom_range(1) == 1;
      for (int k = 0; k < N; k++) enc[k] = $urandom_range(1) == 1;
      rd_addr   = 4'($urandom_range(15));
      tick();
    end
    reset = 1'b0; start = 1'b0; bit_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
